tpu_req_arbiter: RTL

Shares a single TPU_functional multiply datapath (8-bit x 8-bit -> 16-bit) between NUM_REQ requesters. Selects a requester round-robin and drives input1/input2 with a one-cycle sync pulse. Waits for ready or error, strobes out_HL to collect the 16-bit result, and returns it to the owning requester tagged with its ID. Includes a wait-timeout so a hung datapath cannot lock the arbiter.

---
 rtl/tpu_req_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/tpu_req_arbiter.sv
// tpu_req_arbiter
// Shares one 8x8->16 multiply datapath between NUM_REQ requesters.
// Requesters are served round-robin. The chosen operands go to the datapath
// with a one-cycle tpu_sync pulse. The arbiter then waits for tpu_ready or
// tpu_error and strobes tpu_out_hl to collect the product. The result goes
// back as a one-cycle response tagged with the owner's ID. If the datapath
// never answers, a wait timeout forces an error response.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   req_valid[NUM_REQ]    per-requester request, held until req_ack
//   req_a/req_b           packed operands, requester i at [8i+7:8i]
//   req_ack[NUM_REQ]      one-hot accept pulse
//   rsp_valid/rsp_id/rsp_data/rsp_err  one-cycle tagged response
//   busy                  high whenever the arbiter is not idle
//   tpu_sync/tpu_out_hl   start pulse / result-collect strobe to datapath
//   tpu_input1/2          operands to datapath
//   tpu_ready/tpu_error/tpu_out  datapath status and result
//
// Optional feature (macro ARB_STATS_EN): adds stat_ops (16-bit count of good
// responses) and stat_errs (8-bit count of error/timeout responses). Both
// counters saturate at all-ones.
module tpu_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 tpu_sync,
  output logic                 tpu_out_hl,
  output logic [7:0]           tpu_input1,
  output logic [7:0]           tpu_input2,
  input  logic                 tpu_ready,
  input  logic                 tpu_error,
  input  logic [15:0]          tpu_out
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [7:0]           stat_errs
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_READ,
    S_RESP
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    lat_id;
  logic [CNT_W-1:0]   wait_cnt;
  logic [NUM_REQ-1:0] rot;
  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  int                 grant_sum;
  logic [7:0]         op_a;
  logic [7:0]         op_b;
  logic               wait_done;
  logic               wait_err;

  // Round-robin search: rotate the request vector so the pointer sits at
  // bit 0, take the lowest set bit, then map that offset back to an ID.
  always_comb begin
    rot         = NUM_REQ'({req_valid, req_valid} >> ptr);
    grant_found = 1'b0;
    grant_sum   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && rot[k]) begin
        grant_found = 1'b1;
        grant_sum   = int'(ptr) + k;
      end
    end
    if (grant_sum >= NUM_REQ) begin
      grant_sum = grant_sum - NUM_REQ;
    end
    grant_id = ID_W'(grant_sum);
    op_a     = 8'(req_a >> (8 * grant_id));
    op_b     = 8'(req_b >> (8 * grant_id));
  end

  // WAIT exit conditions. Error takes priority over a simultaneous ready.
  // The timeout also counts as an error.
  always_comb begin
    wait_done = tpu_error || tpu_ready || (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
    wait_err  = tpu_error || !tpu_ready;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (grant_found) next_state = S_ISSUE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (wait_done) next_state = wait_err ? S_RESP : S_READ;
      S_READ:  next_state = S_RESP;
      S_RESP:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs and datapath bookkeeping. The pulse outputs default
  // to 0 each cycle and are set only on the transition into the state that
  // owns them. As a result, every output is a flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr        <= '0;
      lat_id     <= '0;
      wait_cnt   <= '0;
      req_ack    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
      tpu_sync   <= 1'b0;
      tpu_out_hl <= 1'b0;
      tpu_input1 <= '0;
      tpu_input2 <= '0;
    end else begin
      req_ack    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
      tpu_sync   <= 1'b0;
      tpu_out_hl <= 1'b0;
      busy       <= (next_state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            lat_id     <= grant_id;
            tpu_input1 <= op_a;
            tpu_input2 <= op_b;
            tpu_sync   <= 1'b1;
            req_ack    <= NUM_REQ'(1) << grant_id;
          end
        end
        S_ISSUE: begin
          ptr <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + ID_W'(1);
        end
        S_WAIT: begin
          if (wait_done) begin
            wait_cnt <= '0;
            if (wait_err) begin
              rsp_valid  <= 1'b1;
              rsp_id     <= lat_id;
              rsp_err    <= 1'b1;
              tpu_input1 <= '0;
              tpu_input2 <= '0;
            end else begin
              tpu_out_hl <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          rsp_valid  <= 1'b1;
          rsp_id     <= lat_id;
          rsp_data   <= tpu_out;
          tpu_input1 <= '0;
          tpu_input2 <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef ARB_STATS_EN
  // Response statistics. Each counter updates on the cycle after the
  // response strobe and saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_valid) begin
      if (rsp_err) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 8'd1;
      end else begin
        if (stat_ops != '1) stat_ops <= stat_ops + 16'd1;
      end
    end
  end
`endif

endmodule
